dm_op_sequencer: RTL and testbench
==================================

Name: dm_op_sequencer

Overview:
- Parametrised data-memory operation engine that drives the datamem port (addr, memWrite, data_in, data_out).
- Performs a vector operation over `len` elements: `mem[dst+i] = mem[src_a+i] OP mem[src_b+i]`.
- Replaces hand-sequenced read/read/combine/write test flows with a start/busy/done handshake.
- Sits between the controller/top level and datamem; it is the only datamem master while busy.

Parameters:
- DW, 8, data word width.
- AW, 8, data-memory address width.
- LW, AW+1, width of `len`; allows up to 2^AW elements.
- RD_LAT, 0, extra wait cycles per read before data_out is sampled; legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code, latched on start.
- src_a  input  AW  first operand base address, latched on start.
- src_b  input  AW  second operand base address, latched on start.
- dst  input  AW  result base address, latched on start.
- len  input  LW  element count, latched on start.
- busy  output  1  high from the cycle after start acceptance until DONE.
- done  output  1  high in DONE; held until the next accepted start.
- err  output  1  illegal op flag; valid while done=1.
- dm_addr  output  AW  datamem address (registered).
- dm_write  output  1  datamem write enable (registered).
- dm_dat_in  output  DW  datamem write data (registered).
- dm_dat_out  input  DW  datamem read data; combinational from dm_addr.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, err=0, dm_addr=0, dm_write=0, dm_dat_in=0; counters and latched operands cleared. Outputs drop immediately, including mid-write.
- Op codes: 0 XOR, 1 AND, 2 OR, 3 ADD mod 2^DW, 4 SUB (a-b) mod 2^DW, 5 PASS_A, 6 NOT_A. Code 7 is illegal.
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE:
  - start=1 with legal op and len>0: latch inputs, clear done/err, idx=0 -> RD_A.
  - start=1 with len=0: -> DONE, err=0, no memory access.
  - start=1 with op=7: -> DONE, err=1, no memory access.
- RD_A: dm_addr=src_a+idx. Hold for 1+RD_LAT cycles, capture dm_dat_out into reg_a on the final cycle -> RD_B.
- RD_B: dm_addr=src_b+idx. Same hold/capture rule into reg_b -> WR.
- WR (exactly 1 cycle): dm_addr=dst+idx, dm_write=1, dm_dat_in=reg_a OP reg_b.
  - If idx==len-1 -> DONE.
  - Otherwise idx++ -> RD_A.
- DONE: busy=0, done=1, dm_write=0. start=1 re-runs the IDLE acceptance rules from DONE (no extra IDLE cycle). Otherwise stay in DONE.
- dm_write is 0 in every state except WR.
- busy=1 in RD_A, RD_B and WR only.
- Address arithmetic wraps modulo 2^AW.
- Latency: (3+2*RD_LAT)*len clock edges from the start-sampling edge to the edge where done rises.
- Each element is read fully before it is written, so in-place operation (dst==src_a or dst==src_b) is well defined.
- start while busy is ignored, and input changes while busy are ignored.
- Overflow and underflow of ADD/SUB are discarded; there is no carry output.

Decomposition:
- Package dm_seq_pkg:
  - op_t enum (OP_XOR..OP_NOT_A, OP_ILLEGAL=7).
  - state_t enum.
  - Default DW/AW constants.
- Sub-module dm_alu: combinational; inputs a, b, op_t; output y[DW]. Instantiated once.

Test Plan:
- mem[0]=0xA5, mem[1]=0x3C; start op=XOR src_a=0 src_b=1 dst=2 len=1, RD_LAT=0 -> mem[2]=0x99; dm_write high exactly 1 cycle; done rises 3 edges after the start edge.
- mem[3]=0xF0, mem[4]=0x3C; op=AND src_a=3 src_b=4 dst=5 len=1 -> mem[5]=0x30; mem[0..4] unchanged.
- mem[0x10..0x13]={0x01,0x7F,0xFF,0x80}, mem[0x20..0x23]={0x01,0x01,0x02,0x80}; op=ADD dst=0x30 len=4 -> mem[0x30..0x33]={0x02,0x80,0x01,0x00}; done after 12 edges. Repeat with RD_LAT=2 -> 28 edges.
- Wrap: src_a=0xFE src_b=0x40 dst=0xFE op=SUB len=3 -> reads at 0xFE,0xFF,0x00, in-place writes at 0xFE,0xFF,0x00 with correct a-b mod 256.
- len=0 -> done=1 and err=0 on the next edge, no dm_write. op=7 len=5 -> done=1, err=1, no dm_write. A following legal start clears err.
- Drive reset=0 mid-WR of element 2 of 4 -> dm_write, busy, done drop asynchronously and element 3 is never written. Separately, pulse start with new operands during busy -> ignored; the original result is unchanged.

Source files
------------

// File: rtl/dm_seq_pkg.sv
// Shared types and default widths for the data-memory operation sequencer.
package dm_seq_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    typedef enum logic [2:0] {
        OP_XOR     = 3'd0,
        OP_AND     = 3'd1,
        OP_OR      = 3'd2,
        OP_ADD     = 3'd3,
        OP_SUB     = 3'd4,
        OP_PASS_A  = 3'd5,
        OP_NOT_A   = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR,
        S_DONE
    } state_t;

endpackage

// File: rtl/dm_alu.sv
// Combinational element operator; ADD/SUB wrap modulo 2^DW with no carry out.
module dm_alu
    import dm_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  op_t           op_i,
    output logic [DW-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_XOR:    y_o = a_i ^ b_i;
            OP_AND:    y_o = a_i & b_i;
            OP_OR:     y_o = a_i | b_i;
            OP_ADD:    y_o = a_i + b_i;
            OP_SUB:    y_o = a_i - b_i;
            OP_PASS_A: y_o = a_i;
            OP_NOT_A:  y_o = ~a_i;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/dm_op_sequencer.sv
// Vector engine: mem[dst+i] = mem[src_a+i] OP mem[src_b+i] for i in [0, len),
// sole datamem master while busy; start/busy/done handshake.
module dm_op_sequencer
    import dm_seq_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int LW     = AW + 1,
    parameter int RD_LAT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] dm_addr,
    output logic          dm_write,
    output logic [DW-1:0] dm_dat_in,
    input  logic [DW-1:0] dm_dat_out
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] src_a_q, src_a_d;
    logic [AW-1:0] src_b_q, src_b_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [DW-1:0] reg_a_q, reg_a_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic          dm_write_q, dm_write_d;
    logic [DW-1:0] dm_dat_in_q, dm_dat_in_d;
    logic          err_q, err_d;
    logic [DW-1:0] alu_y;

    // Operand b goes straight from the read port into the ALU on its capture
    // cycle, so the write data is registered in time for the single WR cycle.
    dm_alu #(.DW(DW)) u_alu (
        .a_i  (reg_a_q),
        .b_i  (dm_dat_out),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        len_d       = len_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        reg_a_d     = reg_a_q;
        dm_addr_d   = dm_addr_q;
        dm_write_d  = 1'b0;
        dm_dat_in_d = dm_dat_in_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (op_t'(op) == OP_ILLEGAL) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (len == '0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        op_d      = op_t'(op);
                        src_a_d   = src_a;
                        src_b_d   = src_b;
                        dst_d     = dst;
                        len_d     = len;
                        idx_d     = '0;
                        wcnt_d    = '0;
                        err_d     = 1'b0;
                        dm_addr_d = src_a;
                        state_d   = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                if (wcnt_q == LAT_LAST) begin
                    reg_a_d   = dm_dat_out;
                    wcnt_d    = '0;
                    dm_addr_d = src_b_q + idx_q[AW-1:0];
                    state_d   = S_RD_B;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_RD_B: begin
                if (wcnt_q == LAT_LAST) begin
                    wcnt_d      = '0;
                    dm_dat_in_d = alu_y;
                    dm_write_d  = 1'b1;
                    dm_addr_d   = dst_q + idx_q[AW-1:0];
                    state_d     = S_WR;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_WR: begin
                if (idx_q == len_q - LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + LW'(1);
                    dm_addr_d = src_a_q + idx_q[AW-1:0] + AW'(1);
                    state_d   = S_RD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_XOR;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            reg_a_q     <= '0;
            dm_addr_q   <= '0;
            dm_write_q  <= 1'b0;
            dm_dat_in_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            reg_a_q     <= reg_a_d;
            dm_addr_q   <= dm_addr_d;
            dm_write_q  <= dm_write_d;
            dm_dat_in_q <= dm_dat_in_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_WR);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign dm_addr   = dm_addr_q;
    assign dm_write  = dm_write_q;
    assign dm_dat_in = dm_dat_in_q;

endmodule

// File: tb/tb_dm_op_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes/completions, negedge monitors pop and compare.
module tb_dm_op_sequencer;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int   lat;
        logic err;
    } dn_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start2;
    logic [2:0] op;
    logic [7:0] src_a, src_b, dst;
    logic [8:0] len;

    logic       busy0, done0, err0, wr0;
    logic [7:0] addr0, din0, dout0;
    logic       busy2, done2, err2, wr2;
    logic [7:0] addr2, din2, dout2;

    logic [7:0] mem0 [256];
    logic [7:0] mem2 [256];
    logic       clr, pk_en;
    logic [7:0] pk_a, pk_d;

    wr_t qw0[$], qw2[$];
    dn_t qd0[$], qd2[$];
    wr_t ew0, ew2;
    dn_t ed0, ed2;
    logic wprev0 = 1'b0, wprev2 = 1'b0, dprev0 = 1'b0, dprev2 = 1'b0;

    int cyc = 0;
    int st0 = 0, st2 = 0;
    int nchk = 0;
    int nerr = 0;

    dm_op_sequencer #(.DW(8), .AW(8), .LW(9), .RD_LAT(0)) u0 (
        .clk(clk), .reset(rst_n), .start(start0), .op(op), .src_a(src_a), .src_b(src_b),
        .dst(dst), .len(len), .busy(busy0), .done(done0), .err(err0), .dm_addr(addr0),
        .dm_write(wr0), .dm_dat_in(din0), .dm_dat_out(dout0)
    );

    dm_op_sequencer #(.DW(8), .AW(8), .LW(9), .RD_LAT(2)) u2 (
        .clk(clk), .reset(rst_n), .start(start2), .op(op), .src_a(src_a), .src_b(src_b),
        .dst(dst), .len(len), .busy(busy2), .done(done2), .err(err2), .dm_addr(addr2),
        .dm_write(wr2), .dm_dat_in(din2), .dm_dat_out(dout2)
    );

    assign dout0 = mem0[addr0];
    assign dout2 = mem2[addr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Memory model: writes land on the negedge of the WR cycle, reads are combinational.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= '0;
                mem2[i] <= '0;
            end
        end else begin
            if (pk_en) begin
                mem0[pk_a] <= pk_d;
                mem2[pk_a] <= pk_d;
            end
            if (wr0) mem0[addr0] <= din0;
            if (wr2) mem2[addr2] <= din2;
        end
    end

    always @(negedge clk) begin
        if (wr0) begin
            chk("wr0_expected", 32'(qw0.size() != 0), 1);
            if (qw0.size() != 0) begin
                ew0 = qw0.pop_front();
                chk("wr0_addr", addr0, ew0.addr);
                chk("wr0_data", din0, ew0.data);
            end
            chk("wr0_single_cycle", wprev0, 0);
        end
        if (done0 && !dprev0) begin
            chk("done0_expected", 32'(qd0.size() != 0), 1);
            if (qd0.size() != 0) begin
                ed0 = qd0.pop_front();
                chk("done0_latency", cyc - st0 - 1, ed0.lat);
                chk("done0_err", err0, ed0.err);
                chk("done0_busy", busy0, 0);
            end
        end
        wprev0 <= wr0;
        dprev0 <= done0;
    end

    always @(negedge clk) begin
        if (wr2) begin
            chk("wr2_expected", 32'(qw2.size() != 0), 1);
            if (qw2.size() != 0) begin
                ew2 = qw2.pop_front();
                chk("wr2_addr", addr2, ew2.addr);
                chk("wr2_data", din2, ew2.data);
            end
            chk("wr2_single_cycle", wprev2, 0);
        end
        if (done2 && !dprev2) begin
            chk("done2_expected", 32'(qd2.size() != 0), 1);
            if (qd2.size() != 0) begin
                ed2 = qd2.pop_front();
                chk("done2_latency", cyc - st2 - 1, ed2.lat);
                chk("done2_err", err2, ed2.err);
            end
        end
        wprev2 <= wr2;
        dprev2 <= done2;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pk_a  = a;
        pk_d  = d;
        pk_en = 1'b1;
        @(negedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic push_wr0(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        qw0.push_back(e);
    endtask

    task automatic push_dn(input bit sel, input int lat, input logic e_err);
        dn_t e;
        e.lat = lat;
        e.err = e_err;
        if (sel) qd2.push_back(e);
        else qd0.push_back(e);
    endtask

    task automatic issue(input bit sel, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input logic [8:0] n);
        @(negedge clk); #1;
        op = o; src_a = a; src_b = b; dst = d; len = n;
        if (sel) begin start2 = 1'b1; st2 = cyc; end
        else begin start0 = 1'b1; st0 = cyc; end
        @(negedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int i = 0;
        while (!(sel ? done2 : done0) && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        if (i >= budget) chk("done_timeout", 0, 1);
    endtask

    task automatic rst_pulse();
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (nchk=%0d)", nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
        op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
        clr = 1'b1; pk_en = 1'b0; pk_a = '0; pk_d = '0;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_write", wr0, 0);
        chk("rst_dat_in", din0, 0);
        @(negedge clk); #1;
        clr = 1'b0;
        rst_n = 1'b1;

        // XOR, single element
        poke(8'h00, 8'hA5); poke(8'h01, 8'h3C);
        push_wr0(8'h02, 8'h99); push_dn(0, 3, 1'b0);
        issue(0, 3'd0, 8'h00, 8'h01, 8'h02, 9'd1);
        wait_done(0, 20);

        // AND, single element; earlier cells untouched
        poke(8'h03, 8'hF0); poke(8'h04, 8'h3C);
        push_wr0(8'h05, 8'h30); push_dn(0, 3, 1'b0);
        issue(0, 3'd1, 8'h03, 8'h04, 8'h05, 9'd1);
        wait_done(0, 20);
        chk("keep_m0", mem0[0], 8'hA5);
        chk("keep_m1", mem0[1], 8'h3C);
        chk("keep_m2", mem0[2], 8'h99);
        chk("keep_m3", mem0[3], 8'hF0);
        chk("keep_m4", mem0[4], 8'h3C);
        chk("m5_and", mem0[5], 8'h30);

        // ADD over 4 elements, RD_LAT=0 then RD_LAT=2
        poke(8'h10, 8'h01); poke(8'h11, 8'h7F); poke(8'h12, 8'hFF); poke(8'h13, 8'h80);
        poke(8'h20, 8'h01); poke(8'h21, 8'h01); poke(8'h22, 8'h02); poke(8'h23, 8'h80);
        push_wr0(8'h30, 8'h02); push_wr0(8'h31, 8'h80);
        push_wr0(8'h32, 8'h01); push_wr0(8'h33, 8'h00);
        push_dn(0, 12, 1'b0);
        issue(0, 3'd3, 8'h10, 8'h20, 8'h30, 9'd4);
        wait_done(0, 40);
        begin
            wr_t e;
            e.addr = 8'h30; e.data = 8'h02; qw2.push_back(e);
            e.addr = 8'h31; e.data = 8'h80; qw2.push_back(e);
            e.addr = 8'h32; e.data = 8'h01; qw2.push_back(e);
            e.addr = 8'h33; e.data = 8'h00; qw2.push_back(e);
        end
        push_dn(1, 28, 1'b0);
        issue(1, 3'd3, 8'h10, 8'h20, 8'h30, 9'd4);
        wait_done(1, 80);
        chk("m2_33", mem2[8'h33], 8'h00);

        // SUB with address wrap, in place over src_a
        poke(8'hFE, 8'h10); poke(8'hFF, 8'h00); poke(8'h00, 8'h05);
        poke(8'h40, 8'h01); poke(8'h41, 8'h01); poke(8'h42, 8'h07);
        push_wr0(8'hFE, 8'h0F); push_wr0(8'hFF, 8'hFF); push_wr0(8'h00, 8'hFE);
        push_dn(0, 9, 1'b0);
        issue(0, 3'd4, 8'hFE, 8'h40, 8'hFE, 9'd3);
        wait_done(0, 40);
        chk("wrap_fe", mem0[8'hFE], 8'h0F);
        chk("wrap_ff", mem0[8'hFF], 8'hFF);
        chk("wrap_00", mem0[8'h00], 8'hFE);

        // len=0, illegal op, then a legal start from DONE clears err
        rst_pulse();
        push_dn(0, 0, 1'b0);
        issue(0, 3'd2, 8'h00, 8'h01, 8'h02, 9'd0);
        wait_done(0, 5);
        rst_pulse();
        push_dn(0, 0, 1'b1);
        issue(0, 3'd7, 8'h00, 8'h01, 8'h02, 9'd5);
        wait_done(0, 5);
        chk("illegal_err_held", err0, 1);
        push_wr0(8'h02, 8'hC2); push_dn(0, 3, 1'b0);
        issue(0, 3'd0, 8'h00, 8'h01, 8'h02, 9'd1);
        wait_done(0, 20);

        // Asynchronous reset during the second element's write
        poke(8'h50, 8'h01); poke(8'h51, 8'h02); poke(8'h52, 8'h03); poke(8'h53, 8'h04);
        poke(8'h60, 8'h10); poke(8'h61, 8'h20); poke(8'h62, 8'h30); poke(8'h63, 8'h40);
        push_wr0(8'h70, 8'h11);
        issue(0, 3'd2, 8'h50, 8'h60, 8'h70, 9'd4);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(posedge clk); #1;
                if (wr0 && addr0 == 8'h71) found = 1'b1;
            end
            chk("rst_mid_wr_reached", 32'(found), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("async_wr_drop", wr0, 0);
        chk("async_busy_drop", busy0, 0);
        chk("async_done_drop", done0, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("abort_m70", mem0[8'h70], 8'h11);
        chk("abort_m71", mem0[8'h71], 8'h00);
        chk("abort_m72", mem0[8'h72], 8'h00);
        chk("abort_m73", mem0[8'h73], 8'h00);

        // start pulsed with new operands while busy is ignored
        poke(8'h80, 8'hF3); poke(8'h81, 8'h0F);
        poke(8'h90, 8'h3F); poke(8'h91, 8'hFF);
        push_wr0(8'hA0, 8'h33); push_wr0(8'hA1, 8'h0F);
        push_dn(0, 6, 1'b0);
        issue(0, 3'd1, 8'h80, 8'h90, 8'hA0, 9'd2);
        @(negedge clk); #1;
        op = 3'd0; src_a = 8'h80; src_b = 8'h90; dst = 8'h00; len = 9'd1;
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        wait_done(0, 30);
        repeat (6) @(negedge clk);
        #1;
        chk("ignored_m00", mem0[8'h00], 8'hFE);
        chk("busy_a0", mem0[8'hA0], 8'h33);
        chk("busy_a1", mem0[8'hA1], 8'h0F);

        chk("qw0_drained", qw0.size(), 0);
        chk("qw2_drained", qw2.size(), 0);
        chk("qd0_drained", qd0.size(), 0);
        chk("qd2_drained", qd2.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
